// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths and FSM state encoding.
package ram_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StRead   = 2'd2
  } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-requester round-robin pick: the pointer breaks ties, a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] winner
);

  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = pointer ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one registered-address RAM, one operation at a time.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic [DATA_W-1:0]   ram_data,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  input  logic [DATA_W-1:0]   ram_q
);

  state_e              state_q;
  logic                ptr_q;
  logic                win_q;
  logic                lat_we_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [DATA_W-1:0]   lat_wdata_q;
  logic [1:0]          winner;
  logic                sel;

  rr_arb2 u_rr_arb2 (
    .req     (req),
    .pointer (ptr_q),
    .winner  (winner)
  );

  assign sel = winner[1];

  // Latched operands stay on the RAM pins through READ so the address is held.
  assign ram_addr = lat_addr_q;
  assign ram_data = lat_wdata_q;

  // The RAM output is only meaningful the cycle after the address was presented.
  assign rdata = (state_q == StRead) ? ram_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      win_q       <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      gnt         <= '0;
      rvalid      <= '0;
      busy        <= 1'b0;
      ram_we      <= 1'b0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      ram_we <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q     <= StAccess;
            win_q       <= sel;
            lat_we_q    <= req_we[sel];
            lat_addr_q  <= sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            lat_wdata_q <= sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            gnt         <= winner;
            ram_we      <= req_we[sel];
            busy        <= 1'b1;
          end
        end
        StAccess: begin
          if (lat_we_q) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            ptr_q   <= ~win_q;
          end else begin
            state_q <= StRead;
            rvalid  <= win_q ? 2'b10 : 2'b01;
          end
        end
        StRead: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          ptr_q   <= ~win_q;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, corner sequences, random traffic.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned DW = DATA_W_DEF;
  localparam int unsigned AW = ADDR_W_DEF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req = '0;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, ram_data, ram_q;
  logic [AW-1:0]   ram_addr;
  logic            busy, ram_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  // Registered-address RAM living beside the arbiter.
  logic [DW-1:0] ram [64] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_data;
    ram_q <= ram[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one op at a time, cycle 1 issues it, cycle 2 returns read data.
  logic [DW-1:0] ref_mem [64] = '{default: '0};
  bit            m_active = 0;
  int            m_cyc = 0;
  bit            m_port = 0;
  bit            m_ptr = 0;
  bit            m_we = 0;
  int            m_addr = 0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_ptr    = 0;
      m_cyc    = 0;
    end else if (m_active) begin
      if (m_cyc == (m_we ? 1 : 2)) begin
        if (m_we) ref_mem[m_addr] = m_data;
        m_active = 0;
        m_ptr    = !m_port;
      end else begin
        m_cyc++;
      end
    end else if (req != 2'b00) begin
      m_port   = (req == 2'b11) ? m_ptr : req[1];
      m_we     = req_we[m_port];
      m_addr   = int'(req_addr[m_port*AW +: AW]);
      m_data   = req_wdata[m_port*DW +: DW];
      m_active = 1;
      m_cyc    = 1;
    end
  end

  always @(posedge clk) begin
    logic [1:0]    e_gnt, e_rv;
    logic [DW-1:0] e_rd;
    logic          e_busy, e_we;
    #1;
    if (!rst) begin
      e_gnt  = (m_active && m_cyc == 1) ? (m_port ? 2'b10 : 2'b01) : 2'b00;
      e_rv   = (m_active && m_cyc == 2) ? (m_port ? 2'b10 : 2'b01) : 2'b00;
      e_rd   = (m_active && m_cyc == 2) ? ref_mem[m_addr] : '0;
      e_busy = m_active;
      e_we   = m_active && m_cyc == 1 && m_we;
      check("model_outputs", {gnt, rvalid, rdata, busy, ram_we},
            {e_gnt, e_rv, e_rd, e_busy, e_we});
      if (m_active) check("model_ram_addr", ram_addr, m_addr);
      if (e_we) check("model_ram_data", ram_data, m_data);
    end
  end

  typedef struct {
    logic [1:0]    req, we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    eg, ev;
    logic [DW-1:0] erd;
    logic          eb, ewe;
    logic [AW-1:0] ea;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] we,
                              input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic [1:0] eg, input logic [1:0] ev,
                              input logic [DW-1:0] erd, input logic eb, input logic ewe,
                              input logic [AW-1:0] ea);
    vec_t v;
    v.req = rq; v.we = we; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.eg = eg; v.ev = ev; v.erd = erd; v.eb = eb; v.ewe = ewe; v.ea = ea;
    return v;
  endfunction

  task automatic set_port(input int i, input logic r, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    req[i] = r;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one op on a port, drop req once granted, return read data when it arrives.
  task automatic do_op(input int i, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic [DW-1:0] rd);
    bit seen;
    rd = '0;
    set_port(i, 1'b1, we, a, d);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (gnt[i]) seen = 1;
    end
    check("op_granted", seen, 1);
    req[i] = 1'b0;
    if (!we && seen) begin
      seen = 0;
      for (int c = 0; c < 5 && !seen; c++) begin
        @(negedge clk);
        if (rvalid[i]) begin
          seen = 1;
          rd = rdata;
        end
      end
      check("op_rvalid", seen, 1);
    end
    for (int c = 0; c < 5 && busy; c++) @(negedge clk);
  endtask

  initial begin
    vec_t          tbl[$];
    logic [DW-1:0] rd;
    int            n;
    bit            exp1;

    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t          tbl[$];
    logic [DW-1:0] rd;
    int            n;
    bit            exp1;

    // Reset state
    @(negedge clk);
    check("reset_outputs", {gnt, rvalid, rdata, busy, ram_we, ram_addr, ram_data}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Simultaneous requests, p0 write A5@3 wins, then p1 reads it back
    tbl.push_back(mk(2'b11, 2'b01, 6'd3, 8'hA5, 6'd3, 8'h00, 2'b01, 2'b00, 8'h00, 1, 1, 6'd3));
    tbl.push_back(mk(2'b10, 2'b00, 6'd3, 8'hA5, 6'd3, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 6'd3));
    tbl.push_back(mk(2'b10, 2'b00, 6'd3, 8'h00, 6'd3, 8'h00, 2'b10, 2'b00, 8'h00, 1, 0, 6'd3));
    tbl.push_back(mk(2'b00, 2'b00, 6'd3, 8'h00, 6'd3, 8'h00, 2'b00, 2'b10, 8'hA5, 1, 0, 6'd3));
    tbl.push_back(mk(2'b00, 2'b00, 6'd3, 8'h00, 6'd3, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 6'd3));
    // p0 writes 01@0 then reads @0
    tbl.push_back(mk(2'b01, 2'b01, 6'd0, 8'h01, 6'd0, 8'h00, 2'b01, 2'b00, 8'h00, 1, 1, 6'd0));
    tbl.push_back(mk(2'b00, 2'b00, 6'd0, 8'h00, 6'd0, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 6'd0));
    tbl.push_back(mk(2'b01, 2'b00, 6'd0, 8'h00, 6'd0, 8'h00, 2'b01, 2'b00, 8'h00, 1, 0, 6'd0));
    tbl.push_back(mk(2'b00, 2'b00, 6'd0, 8'h00, 6'd0, 8'h00, 2'b00, 2'b01, 8'h01, 1, 0, 6'd0));
    tbl.push_back(mk(2'b00, 2'b00, 6'd0, 8'h00, 6'd0, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 6'd0));
    // p1 writes 04@1, p0 reads @1
    tbl.push_back(mk(2'b10, 2'b10, 6'd0, 8'h00, 6'd1, 8'h04, 2'b10, 2'b00, 8'h00, 1, 1, 6'd1));
    tbl.push_back(mk(2'b00, 2'b00, 6'd0, 8'h00, 6'd1, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 6'd1));
    tbl.push_back(mk(2'b01, 2'b00, 6'd1, 8'h00, 6'd0, 8'h00, 2'b01, 2'b00, 8'h00, 1, 0, 6'd1));
    tbl.push_back(mk(2'b00, 2'b00, 6'd1, 8'h00, 6'd0, 8'h00, 2'b00, 2'b01, 8'h04, 1, 0, 6'd1));
    tbl.push_back(mk(2'b00, 2'b00, 6'd1, 8'h00, 6'd0, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 6'd1));
    // Top address: p1 writes 5C@63, p0 reads @63
    tbl.push_back(mk(2'b10, 2'b10, 6'd0, 8'h00, 6'd63, 8'h5C, 2'b10, 2'b00, 8'h00, 1, 1, 6'd63));
    tbl.push_back(mk(2'b00, 2'b00, 6'd0, 8'h00, 6'd63, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 6'd63));
    tbl.push_back(mk(2'b01, 2'b00, 6'd63, 8'h00, 6'd0, 8'h00, 2'b01, 2'b00, 8'h00, 1, 0, 6'd63));
    tbl.push_back(mk(2'b00, 2'b00, 6'd63, 8'h00, 6'd0, 8'h00, 2'b00, 2'b01, 8'h5C, 1, 0, 6'd63));
    tbl.push_back(mk(2'b00, 2'b00, 6'd63, 8'h00, 6'd0, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 6'd63));

    foreach (tbl[k]) begin
      req = tbl[k].req;
      req_we = tbl[k].we;
      req_addr = {tbl[k].a1, tbl[k].a0};
      req_wdata = {tbl[k].d1, tbl[k].d0};
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_gnt", k), gnt, tbl[k].eg);
      check($sformatf("vec%0d_rvalid", k), rvalid, tbl[k].ev);
      check($sformatf("vec%0d_rdata", k), rdata, tbl[k].erd);
      check($sformatf("vec%0d_busy", k), busy, tbl[k].eb);
      check($sformatf("vec%0d_ram_we", k), ram_we, tbl[k].ewe);
      if (tbl[k].eb) check($sformatf("vec%0d_ram_addr", k), ram_addr, tbl[k].ea);
    end

    // Continuous requests from both ports alternate 0,1,0,1 after reset
    do_reset();
    set_port(0, 1'b1, 1'b0, 6'd2, 8'h00);
    set_port(1, 1'b1, 1'b0, 6'd4, 8'h00);
    n = 0;
    exp1 = 0;
    for (int c = 0; c < 100 && n < 8; c++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        check("alt_gnt", gnt, exp1 ? 2'b10 : 2'b01);
        exp1 = !exp1;
        n++;
      end
    end
    check("alt_count", n, 8);
    req = '0;
    for (int c = 0; c < 3; c++) @(negedge clk);

    // Reset during the ACCESS cycle of a write aborts it
    do_op(0, 1'b1, 6'd5, 8'h33, rd);
    set_port(0, 1'b1, 1'b1, 6'd5, 8'hFF);
    @(negedge clk);
    check("abort_we_before", ram_we, 1'b1);
    rst = 1'b1;
    req = '0;
    #1;
    check("abort_we_after", ram_we, 1'b0);
    check("abort_quiet", {gnt, rvalid, busy}, '0);
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 1'b0, 6'd5, 8'h00, rd);
    check("abort_kept_value", rd, 8'h33);

    // Random traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic [AW-1:0] a;
        a = ($urandom_range(3) == 0) ? 6'd63 : AW'($urandom_range(7));
        if (gnt[i]) begin
          if ($urandom_range(1) == 1) set_port(i, 1'b1, 1'($urandom), a, 8'($urandom));
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(2) == 0) begin
          set_port(i, 1'b1, 1'($urandom), a, 8'($urandom));
        end
      end
    end
    req = '0;
    for (int c = 0; c < 5; c++) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, 8, RAM word width.
REQ-002 Parameter ADDR_W, 6, RAM address width (64 words).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  2  per-requester access request; bit i = requester i.
REQ-006 req_we  in  2  per-requester op type: 1 write, 0 read.
REQ-007 req_addr  in  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
REQ-008 req_wdata  in  2*DATA_W  requester i write data in bits [i*DATA_W +: DATA_W].
REQ-009 gnt  out  2  one-hot, one-cycle pulse: op of requester i issued to RAM.
REQ-010 rvalid  out  2  one-hot, one-cycle pulse: rdata holds requester i read result.
REQ-011 rdata  out  DATA_W  shared read-data bus.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 ram_data  out  DATA_W  to RAM data input.
REQ-014 ram_addr  out  ADDR_W  to RAM address input.
REQ-015 ram_we  out  1  to RAM write enable.
REQ-016 ram_q  in  DATA_W  from RAM output; valid one clock edge after address is presented (registered-address RAM).

Function
REQ-017 FSM shall have states IDLE, ACCESS, READ; at most one operation outstanding.
REQ-018 IDLE: if req != 0, select winner, latch winner's we/addr/wdata into internal registers, go ACCESS; else stay IDLE.
REQ-019 Arbitration shall be round-robin: pointer names the preferred requester; if both request, pointer wins; if one requests, it wins.
REQ-020 Pointer shall update to the non-winner when the winner's operation completes (end of ACCESS for write, end of READ for read).
REQ-021 ACCESS: ram_addr/ram_data/ram_we driven from latched registers, gnt[winner]=1 for exactly this cycle.
REQ-022 ACCESS with write: ram_we=1 this cycle only, next state IDLE (write occupies 2 cycles total).
REQ-023 ACCESS with read: ram_we=0, next state READ.
REQ-024 READ: rvalid[winner]=1, rdata=ram_q, ram_addr held, ram_we=0; next state IDLE (read occupies 3 cycles total).
REQ-025 Outside READ, rdata shall be 0 and rvalid shall be 0.
REQ-026 ram_we shall never be 1 outside ACCESS; gnt and rvalid never have more than one bit set.
REQ-027 Requester shall hold req/we/addr/wdata stable until it sees gnt and drop req the cycle after; a req still high in IDLE starts a new operation.
REQ-028 Request changes while busy shall be ignored until next IDLE; no op is lost or duplicated.
REQ-029 Back-to-back: continuous requests from both ports shall alternate strictly 0,1,0,1 after reset.

Reset
REQ-030 rst high shall immediately force state IDLE, pointer=0, gnt=0, rvalid=0, busy=0, ram_we=0, ram_addr=0, ram_data=0, rdata=0, latched registers=0.
REQ-031 Reset during ACCESS shall abort the op: ram_we drops asynchronously; no gnt/rvalid issued after reset; op is not retried.
REQ-032 First arbitration after reset release occurs on the first rising edge with rst low and req != 0.

Structure
REQ-033 State encodings (IDLE=0, ACCESS=1, READ=2) and DATA_W/ADDR_W defaults shall live in a shared package/header used by arbiter and bench.
REQ-034 Round-robin pick logic shall be a sub-module rr_arb2 (inputs req[1:0], pointer; output one-hot winner); the RAM is instantiated beside, not inside, ram_arbiter.

Verification
REQ-035 Port 0 writes 0x01@0, then reads @0 -> gnt[0] in ACCESS, ram_we one cycle, then 3 cycles later rvalid[0]=1, rdata=0x01.
REQ-036 Both ports request simultaneously after reset (p0 write 0xA5@3, p1 read @3) -> p0 granted first, then p1 reads 0xA5 with rvalid[1].
REQ-037 Both ports hold req continuously for 8 ops -> grants alternate 0,1,0,1..., no cycle with two gnt bits.
REQ-038 Port 1 writes 0x04@1 while p0 idle, then p0 reads @1 -> rdata=0x04 on rvalid[0]; busy high exactly during ACCESS/READ.
REQ-039 Assert rst during ACCESS of a write 0xFF@5 -> ram_we drops immediately, later read @5 does not return 0xFF (prior value kept).
REQ-040 Read @63 and write @63 (address boundary) -> correct data, no address wrap or truncation.
